// File: rtl/gcd_top.sv
// ---------------------------------------------------------------------------
// gcd_top
//
// Iterative GCD engine based on repeated subtraction. When the block is idle
// and start is high, it captures A and B. It then runs one subtract step per
// clock until one operand is zero or both are equal. The result is then
// registered on res and marked with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2), default 5
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   level request, only looked at in IDLE
//   A, B   in   unsigned operands, captured together with start
//   res    out  registered GCD; holds the last result between completions
//   done   out  registered one-cycle pulse when res shows a new result
//   busy   out  registered, high while the FSM is in CALC
//   err    out  (only with GCD_ERR_EN) set with done when both terminating
//               operands are zero, otherwise cleared with done
//
// Build option:
//   GCD_ERR_EN  when defined, adds the err output and its logic
// ---------------------------------------------------------------------------
module gcd_top #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic             done,
`ifdef GCD_ERR_EN
    output logic             busy,
    output logic             err
`else
    output logic             busy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, a_nxt;
    logic [WIDTH-1:0] b, b_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             done_nxt;
    logic             busy_nxt;
    logic             term;

`ifdef GCD_ERR_EN
    logic             err_nxt;
`endif

    // Termination test for the current operand pair.
    assign term = (a == b) || (a == '0) || (b == '0);

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        res_nxt   = res;
        done_nxt  = 1'b0;
`ifdef GCD_ERR_EN
        err_nxt   = err;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    a_nxt     = A;
                    b_nxt     = B;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (term) begin
                    // gcd(0,x)=x; when both are zero b is zero as well.
                    res_nxt   = (a == '0) ? b : a;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
`ifdef GCD_ERR_EN
                    err_nxt   = (a == '0) && (b == '0);
`endif
                end else if (a > b) begin
                    // Larger operand is always the minuend, so no wrap.
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                // Unused fourth code recovers to IDLE.
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef GCD_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            res   <= res_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
`ifdef GCD_ERR_EN
            err   <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_top.sv
module tb_gcd_top;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] res;
    logic         done;
    logic         busy;
`ifdef GCD_ERR_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gcd_top #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .res   (res),
        .done  (done),
`ifdef GCD_ERR_EN
        .busy  (busy),
        .err   (err)
`else
        .busy  (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           res;
        int           n;
        logic         err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request; the start-sampling edge is counted as edge 1, so a
    // pair needing N subtractions shows done at edge N+2. a_late/b_late are
    // driven onto A/B after the start edge to prove they are ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] a_late, input logic [W-1:0] b_late,
                          input int exp_res, input int exp_n, input string name);
        int lat;
        int bcnt;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0; A = a_late; B = b_late;
        for (int k = 2; k <= 80 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
            else if (busy) bcnt++;
        end
        check({name, " latency"}, lat, exp_n + 2);
        check({name, " res"}, int'(res), exp_res);
        check({name, " busy cycles"}, bcnt, exp_n + 1);
        @(posedge clk); #1;
        check({name, " done pulse width"}, int'(done), 0);
        check({name, " res hold"}, int'(res), exp_res);
    endtask

    initial begin
        vecs[0]  = '{a: 5'd8,  b: 5'd8,  res: 8,  n: 0,  err: 1'b0};
        vecs[1]  = '{a: 5'd12, b: 5'd8,  res: 4,  n: 2,  err: 1'b0};
        vecs[2]  = '{a: 5'd31, b: 5'd1,  res: 1,  n: 30, err: 1'b0};
        vecs[3]  = '{a: 5'd1,  b: 5'd31, res: 1,  n: 30, err: 1'b0};
        vecs[4]  = '{a: 5'd0,  b: 5'd9,  res: 9,  n: 0,  err: 1'b0};
        vecs[5]  = '{a: 5'd0,  b: 5'd0,  res: 0,  n: 0,  err: 1'b1};
        vecs[6]  = '{a: 5'd9,  b: 5'd0,  res: 9,  n: 0,  err: 1'b0};
        vecs[7]  = '{a: 5'd18, b: 5'd24, res: 6,  n: 3,  err: 1'b0};
        vecs[8]  = '{a: 5'd17, b: 5'd13, res: 1,  n: 7,  err: 1'b0};
        vecs[9]  = '{a: 5'd30, b: 5'd25, res: 5,  n: 5,  err: 1'b0};
        vecs[10] = '{a: 5'd16, b: 5'd31, res: 1,  n: 16, err: 1'b0};
        vecs[11] = '{a: 5'd21, b: 5'd14, res: 7,  n: 2,  err: 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        @(posedge clk); #1;
        check("reset res", int'(res), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
`ifdef GCD_ERR_EN
        check("reset err", int'(err), 0);
`endif

        // Start held high from the first non-reset edge; res must stay 8.
        @(negedge clk);
        rst = 1'b0; start = 1'b1; A = 5'd8; B = 5'd8;
        begin
            int lat;
            lat = 0;
            for (int k = 1; k <= 10 && lat == 0; k++) begin
                @(posedge clk); #1;
                if (done) lat = k;
            end
            check("held start latency", lat, 2);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                check("held start res stable", int'(res), 8);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);

        // Table-driven operand pairs.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].n, $sformatf("vec%0d", i));
`ifdef GCD_ERR_EN
            check($sformatf("vec%0d err", i), int'(err), int'(vecs[i].err));
`endif
        end

        // Operands changing while the computation runs have no effect.
        run_op(5'd21, 5'd14, 5'd5, 5'd3, 7, 2, "late A/B change");

        // Reset in the middle of a long computation discards it.
        @(negedge clk);
        A = 5'd31; B = 5'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy before abort", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 5'd12; B = 5'd8;
        @(posedge clk); #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort res", int'(res), 0);
        // Start is ignored while reset is held.
        @(posedge clk); #1;
        check("start under reset busy", int'(busy), 0);
        check("start under reset res", int'(res), 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        run_op(5'd12, 5'd8, 5'd12, 5'd8, 4, 2, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_top.md
GCD_TOP -- requirements
Module: gcd_top

Interface
REQ-001 Parameter: WIDTH, default 5, operand and result bit width (WIDTH >= 2).
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  level request; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  first operand, unsigned; sampled with start.
REQ-006 Port: B  input  WIDTH  second operand, unsigned; sampled with start.
REQ-007 Port: res  output  WIDTH  registered GCD result; holds the last result until the next completion.
REQ-008 Port: done  output  1  registered; one-cycle pulse, high in the cycle res first shows a new result.
REQ-009 Port: busy  output  1  high while in CALC.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE, encoded in 2 bits; the fourth code SHALL go to IDLE.
REQ-011 IDLE with start=1 SHALL load internal registers a<=A and b<=B and move to CALC; IDLE with start=0 SHALL stay in IDLE.
REQ-012 CALC SHALL do one step per cycle: if a==b or a==0 or b==0, terminate; else if a>b then a<=a-b, else b<=b-a.
REQ-013 On terminate: res<=(a==0)?b:a, done<=1, next state DONE; a and b are unchanged.
REQ-014 DONE SHALL return to IDLE after one cycle with done<=0; res SHALL hold its value.
REQ-015 Latency: for an operand pair needing N subtractions, done SHALL be high N+2 cycles after the start-sampling edge.
  - (8,8) -> N=0, done 2 cycles after the start edge
  - (12,8) -> N=2, done 4 cycles after the start edge
REQ-016 Worst case (WIDTH=5, operands 31 and 1) SHALL be N=30.
REQ-017 Subtraction SHALL be WIDTH-bit unsigned and never underflow; the larger operand is always the minuend.
REQ-018 If start stays high, the block SHALL restart from IDLE using the current A/B; res SHALL stay stable until the next done.
REQ-019 A and B changes during CALC or DONE SHALL have no effect.
REQ-020 Zero operands: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0; each SHALL terminate in the first CALC cycle.

Reset
REQ-021 With rst=1 at a clock edge: state<=IDLE, a<=0, b<=0, res<=0, done<=0, busy<=0 (and err<=0 if present).
REQ-022 Reset SHALL override all other activity, including start and a computation in CALC or DONE; the aborted result SHALL be discarded.
REQ-023 Start SHALL be ignored in any cycle where rst=1; the first computation starts at the first edge with rst=0 and start=1.

Configuration
REQ-024 Macro GCD_ERR_EN defined: the block SHALL add output err (1 bit, registered).
  - err is set with done when the terminating operands are both zero, otherwise cleared with done.
  - err holds between completions.
REQ-025 Macro GCD_ERR_EN undefined: no err port and no err logic; all other behaviour is identical.

Verification
REQ-026 rst=1 for 1 cycle, then start=1, A=8, B=8 -> res=8 with done pulse 2 cycles after the start edge; res stays 8 for the next 10 cycles with start held high.
REQ-027 rst=1 mid-run, then start=1, A=12, B=8 -> res=0 during reset, then res=4 with done 4 cycles after the start edge.
REQ-028 A=31, B=1 -> busy high for 31 cycles, then res=1 and done.
REQ-029 A=0, B=9 -> res=9; A=0, B=0 -> res=0, err=1 when GCD_ERR_EN is defined.
REQ-030 A=21, B=14; change A to 5 during CALC -> res=7, unaffected by the change.
REQ-031 Assert rst=1 while busy=1 -> next cycle state IDLE, res=0, done=0, busy=0.
